// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output serializer: sample/frame geometry,
// FSM state encoding and a bin-select helper.
package fft_pkg;

   localparam int DATA_W  = 32;
   localparam int HALF_W  = DATA_W / 2;
   localparam int NPOINT  = 16;
   localparam int IDX_W   = $clog2(NPOINT);
   localparam int FRAME_W = NPOINT * DATA_W;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOINT - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   // Select complex bin 'idx' out of a natural-order frame.
   function automatic logic [DATA_W-1:0] bin_of(input logic [FRAME_W-1:0] frame,
                                                input logic [IDX_W-1:0]   idx);
      return frame[idx*DATA_W +: DATA_W];
   endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// One frame of NPOINT complex samples held in registers, with a full flag.
// 'load' captures data_in and sets full; 'drain' clears full without
// touching the stored samples. Reset empties the buffer and zeroes the data.
module fft_frame_buf
   import fft_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               drain,
   input  logic [FRAME_W-1:0] data_in,
   output logic [FRAME_W-1:0] data_out,
   output logic               full
);

   logic [FRAME_W-1:0] data_q, data_d;
   logic               full_q, full_d;

   // Next contents: a load wins over a drain issued in the same cycle.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (load) begin
         data_d = data_in;
         full_d = 1'b1;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   // Storage registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign data_out = data_q;
   assign full     = full_q;

endmodule

// File: rtl/fft_out_serializer.sv
// Streams one 16-point FFT result frame out as one bin per beat over a
// valid/ready interface, each beat split into signed real/imag halves.
// Optional feature macro: FFT_OUT_DBUF_EN adds a pending buffer so a new
// frame can be accepted while the current one streams (no bubble between
// frames). Without it a single buffer costs one idle cycle per frame.
module fft_out_serializer
   import fft_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     frame_valid,
   output logic                     frame_ready,
   input  logic [NPOINT*DATA_W-1:0] frame_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W/2-1:0]      out_real,
   output logic [DATA_W/2-1:0]      out_img,
   output logic [IDX_W-1:0]         out_idx,
   output logic                     out_last
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   logic               frame_xfer;
   logic               beat_xfer;
   logic               last_xfer;

   logic               act_load;
   logic               act_drain;
   logic               act_full;
   logic [FRAME_W-1:0] act_din;
   logic [FRAME_W-1:0] act_data;
   logic [DATA_W-1:0]  cur_bin;

`ifdef FFT_OUT_DBUF_EN
   logic               pend_load;
   logic               pend_drain;
   logic               pend_full;
   logic [FRAME_W-1:0] pend_data;
`endif

   assign frame_xfer = frame_valid & frame_ready;
   assign beat_xfer  = out_valid & out_ready;
   assign last_xfer  = beat_xfer & (idx_q == LAST_IDX);

   // Buffer steering: decide which buffer captures an accepted frame and
   // when the active buffer is released or refilled.
`ifdef FFT_OUT_DBUF_EN
   always_comb begin
      act_load   = 1'b0;
      act_drain  = 1'b0;
      act_din    = frame_data;
      pend_load  = 1'b0;
      pend_drain = 1'b0;
      if (last_xfer && pend_full) begin
         act_load   = 1'b1;
         act_din    = pend_data;
         pend_drain = 1'b1;
      end else if (frame_xfer && ((state_q == ST_IDLE) || last_xfer)) begin
         act_load   = 1'b1;
      end else if (frame_xfer) begin
         pend_load  = 1'b1;
      end
      if (last_xfer && !act_load) begin
         act_drain  = 1'b1;
      end
   end
`else
   always_comb begin
      act_load  = frame_xfer;
      act_drain = last_xfer;
      act_din   = frame_data;
   end
`endif

   fft_frame_buf u_act_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (act_load),
      .drain    (act_drain),
      .data_in  (act_din),
      .data_out (act_data),
      .full     (act_full)
   );

`ifdef FFT_OUT_DBUF_EN
   fft_frame_buf u_pend_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (pend_load),
      .drain    (pend_drain),
      .data_in  (frame_data),
      .data_out (pend_data),
      .full     (pend_full)
   );
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: stream while the active buffer holds a frame.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (act_load) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (last_xfer && !act_load) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: handshake flags derived from state and buffer occupancy.
   always_comb begin
      out_valid   = (state_q == ST_STREAM) & act_full;
`ifdef FFT_OUT_DBUF_EN
      frame_ready = !pend_full;
`else
      frame_ready = (state_q == ST_IDLE);
`endif
   end

   // Bin index: advances on each accepted beat, restarts at 0 for each frame.
   always_comb begin
      idx_d = idx_q;
      if (last_xfer || (act_load && (state_q == ST_IDLE))) begin
         idx_d = '0;
      end else if (beat_xfer) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   // Bin index register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   // Output slicing: pure selection of the current bin, no arithmetic.
   always_comb begin
      cur_bin  = bin_of(act_data, idx_q);
      out_real = cur_bin[DATA_W-1:HALF_W];
      out_img  = cur_bin[HALF_W-1:0];
      out_idx  = idx_q;
      out_last = out_valid & (idx_q == LAST_IDX);
   end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer. A reference model expands
// every accepted frame into its expected sequence of beats; each
// transferred beat is checked against it, and scenario tasks add their own
// timing and boundary checks. Works with or without FFT_OUT_DBUF_EN.
`timescale 1ns/1ps
module tb_fft_out_serializer;
   import fft_pkg::*;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [HALF_W-1:0] re;
      logic [HALF_W-1:0] im;
      logic              last;
   } beat_t;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b1;
   logic                     frame_valid = 1'b0;
   logic                     frame_ready;
   logic [NPOINT*DATA_W-1:0] frame_data = '0;
   logic                     out_valid;
   logic                     out_ready = 1'b0;
   logic [HALF_W-1:0]        out_real;
   logic [HALF_W-1:0]        out_img;
   logic [IDX_W-1:0]         out_idx;
   logic                     out_last;

   beat_t exp_q[$];
   int    vectors = 0;
   int    miscompares = 0;
   int    cycles = 0;
   int    beats = 0;
   int    accepts = 0;
   int    first_beat_cyc = -1;
   int    last_beat_cyc = -1;
   int    last_accept_cyc = -1;
   int    accept_period = 0;
   logic  prev_stall = 1'b0;
   beat_t prev_snap = '0;

   fft_out_serializer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_data  (frame_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_real    (out_real),
      .out_img     (out_img),
      .out_idx     (out_idx),
      .out_last    (out_last)
   );

   always #5 clk = ~clk;

   // Fill the input frame with random samples.
   task automatic rand_frame();
      for (int k = 0; k < NPOINT; k++) begin
         frame_data[k*DATA_W +: DATA_W] = $urandom;
      end
   endtask

   // One clock cycle: observe at the falling edge, update the model, return
   // just after the next rising edge so the caller can drive new inputs.
   task automatic tick();
      beat_t got;
      beat_t e;
      @(negedge clk);
      cycles++;
      got = '{idx: out_idx, re: out_real, im: out_img, last: out_last};
      if (prev_stall) begin
         vectors++;
         if (!(out_valid === 1'b1 && got === prev_snap)) begin
            miscompares++;
            $display("[TB] FAIL stall_hold cycle %0d: got valid=%b beat=%h required valid=1 beat=%h",
                     cycles, out_valid, got, prev_snap);
         end
      end
      if (out_valid === 1'b1 && out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_beat cycle %0d: got beat=%h required no beat", cycles, got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               miscompares++;
               $display("[TB] FAIL beat_data cycle %0d: got idx=%0d re=%h im=%h last=%b required idx=%0d re=%h im=%h last=%b",
                        cycles, got.idx, got.re, got.im, got.last, e.idx, e.re, e.im, e.last);
            end
         end
         beats++;
         if (first_beat_cyc < 0) first_beat_cyc = cycles;
         last_beat_cyc = cycles;
      end
      if (frame_valid && frame_ready === 1'b1) begin
         for (int k = 0; k < NPOINT; k++) begin
            e.idx  = IDX_W'(k);
            e.re   = frame_data[k*DATA_W + HALF_W +: HALF_W];
            e.im   = frame_data[k*DATA_W +: HALF_W];
            e.last = (k == NPOINT - 1);
            exp_q.push_back(e);
         end
         accepts++;
         accept_period   = cycles - last_accept_cyc;
         last_accept_cyc = cycles;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_snap  = got;
      @(posedge clk);
      #1;
   endtask

   // Reset values, then an asynchronous reset in the middle of a frame.
   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({out_valid, out_idx, out_last, out_real, out_img, frame_ready} !== {1'b0, 4'd0, 1'b0, 16'd0, 16'd0, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL reset_values: got valid=%b idx=%0d last=%b re=%h im=%h frame_ready=%b required 0 0 0 0000 0000 1",
                  out_valid, out_idx, out_last, out_real, out_img, frame_ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      rand_frame();
      frame_valid = 1'b1;
      out_ready   = 1'b1;
      tick();
      frame_valid = 1'b0;
      repeat (5) tick();
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 4'd5) begin
         miscompares++;
         $display("[TB] FAIL pre_reset_idx: got valid=%b idx=%0d required valid=1 idx=5", out_valid, out_idx);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_idx !== 4'd0 || out_last !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midframe_reset: got valid=%b idx=%0d last=%b required 0 0 0", out_valid, out_idx, out_last);
      end
      exp_q.delete();
      prev_stall = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      vectors++;
      if (frame_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ready_after_reset: got %b required 1", frame_ready);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL no_beats_after_reset cycle %0d: got valid=%b required 0", c, out_valid);
         end
      end
   endtask

   // Known ramp frame {k, -k}: index sequence, last flag and first-beat latency.
   task automatic test_single_frame();
      for (int k = 0; k < NPOINT; k++) begin
         frame_data[k*DATA_W +: DATA_W] = {HALF_W'(k), HALF_W'(-k)};
      end
      frame_valid = 1'b1;
      out_ready   = 1'b1;
      tick();
      frame_valid = 1'b0;
      for (int b = 0; b < NPOINT; b++) begin
         vectors++;
         if (out_valid !== 1'b1 || out_idx !== IDX_W'(b) || out_last !== (b == NPOINT - 1)) begin
            miscompares++;
            $display("[TB] FAIL single_seq beat %0d: got valid=%b idx=%0d last=%b required valid=1 idx=%0d last=%b",
                     b, out_valid, out_idx, out_last, b, (b == NPOINT - 1));
         end
         if (b == 3) begin
            vectors++;
            if (out_real !== 16'd3 || out_img !== 16'hFFFD) begin
               miscompares++;
               $display("[TB] FAIL bin3_value: got re=%h im=%h required re=0003 im=fffd", out_real, out_img);
            end
         end
         tick();
      end
      vectors++;
      if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL single_end: got valid=%b pending=%0d required valid=0 pending=0", out_valid, exp_q.size());
      end
   endtask

   // Sink stalls on cycles 2, 3 and 7 of a frame.
   task automatic test_backpressure();
      int b0;
      rand_frame();
      frame_valid = 1'b1;
      out_ready   = 1'b1;
      tick();
      frame_valid = 1'b0;
      b0 = beats;
      for (int c = 0; c < 40 && (beats - b0) < NPOINT; c++) begin
         out_ready = !(c == 2 || c == 3 || c == 7);
         tick();
      end
      out_ready = 1'b1;
      vectors++;
      if ((beats - b0) != NPOINT || exp_q.size() != 0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL backpressure_count: got beats=%0d pending=%0d valid=%b required 16 0 0",
                  beats - b0, exp_q.size(), out_valid);
      end
   endtask

   // Three frames with frame_valid and out_ready held high: accept timing,
   // ignored/pending frames and total stream length.
   task automatic test_back_to_back();
      int a0;
      int b0;
      int prev_acc;
      int span;
      a0 = accepts;
      b0 = beats;
      first_beat_cyc  = -1;
      last_accept_cyc = -1;
      rand_frame();
      frame_valid = 1'b1;
      out_ready   = 1'b1;
      for (int c = 0; c < 200 && ((accepts - a0) < 3 || exp_q.size() > 0); c++) begin
         prev_acc = accepts;
         tick();
         if (accepts != prev_acc) begin
            if ((accepts - a0) == 1) begin
               vectors++;
`ifdef FFT_OUT_DBUF_EN
               if (frame_ready !== 1'b1) begin
`else
               if (frame_ready !== 1'b0) begin
`endif
                  miscompares++;
                  $display("[TB] FAIL ready_while_streaming: got %b", frame_ready);
               end
            end else begin
               vectors++;
`ifdef FFT_OUT_DBUF_EN
               if (accept_period != (((accepts - a0) == 2) ? 1 : NPOINT)) begin
                  miscompares++;
                  $display("[TB] FAIL accept_period frame %0d: got %0d required %0d",
                           accepts - a0, accept_period, ((accepts - a0) == 2) ? 1 : NPOINT);
               end
`else
               if (accept_period != NPOINT + 1) begin
                  miscompares++;
                  $display("[TB] FAIL accept_period frame %0d: got %0d required %0d",
                           accepts - a0, accept_period, NPOINT + 1);
               end
`endif
            end
            if ((accepts - a0) == 3) frame_valid = 1'b0;
            else rand_frame();
         end
      end
      frame_valid = 1'b0;
      span = last_beat_cyc - first_beat_cyc + 1;
      vectors++;
`ifdef FFT_OUT_DBUF_EN
      if ((accepts - a0) != 3 || (beats - b0) != 3*NPOINT || span != 3*NPOINT) begin
`else
      if ((accepts - a0) != 3 || (beats - b0) != 3*NPOINT || span != 3*NPOINT + 2) begin
`endif
         miscompares++;
         $display("[TB] FAIL back_to_back: got frames=%0d beats=%0d span=%0d", accepts - a0, beats - b0, span);
      end
   endtask

   // 200 random frames with random valid/ready against the reference model.
   task automatic test_scoreboard();
      int a0;
      int b0;
      int prev_acc;
      a0 = accepts;
      b0 = beats;
      frame_valid = 1'b0;
      for (int c = 0; c < 30000 && (accepts - a0) < 200; c++) begin
         if (!frame_valid) begin
            rand_frame();
            frame_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         prev_acc = accepts;
         tick();
         if (accepts != prev_acc) frame_valid = 1'b0;
      end
      frame_valid = 1'b0;
      for (int c = 0; c < 3000 && exp_q.size() > 0; c++) begin
         out_ready = $urandom_range(0, 1);
         tick();
      end
      out_ready = 1'b1;
      vectors++;
      if ((accepts - a0) != 200 || (beats - b0) != 200*NPOINT || exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_totals: got frames=%0d beats=%0d pending=%0d required 200 3200 0",
                  accepts - a0, beats - b0, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_back_to_back();
      test_scoreboard();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
